pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Parametrised fetch-PC generator; replaces the combinational next-PC adder with a registered PC
//  and a valid/ready handshake to fetch. Resolves branch/JAL/JALR redirects from execute and traps.
//  Detects misaligned targets and halts fetch until a trap. Counts redirects (perf counter).
// PARAMETERS
//  XLEN          32          address/data width
//  RESET_VECTOR  32'h0       PC presented after reset
//  C_EXT         0           1: 2-byte alignment (target[0] checked); 0: 4-byte (target[1:0] checked)
//  CNT_W         16          width of redirect counter, saturating
// PORTS
//  clk           in   1      clock, rising edge
//  rstn          in   1      async active-low reset
//  pc_o          out  XLEN   PC offered to fetch
//  pc_valid_o    out  1      pc_o valid
//  pc_ready_i    in   1      fetch accepts pc_o when pc_valid_o && pc_ready_i
//  ex_valid_i    in   1      execute presents a resolved control-flow op
//  ex_pcsrc_i    in   3      0=PLUS4 1=BRANCH 2=JUMP 3=JALR; 4..7 treated as PLUS4
//  ex_taken_i    in   1      branch outcome (BRANCH only)
//  ex_pc_i       in   XLEN   PC of resolving instruction
//  ex_imm_i      in   XLEN   sign-extended immediate
//  ex_rs1_i      in   XLEN   rs1 value (JALR)
//  trap_i        in   1      take trap this cycle
//  trap_vec_i    in   XLEN   trap target
//  flush_o       out  1      comb; redirect/trap this cycle, fetch drops anything accepted this cycle
//  misalign_o    out  1      1-cycle registered pulse: misaligned target detected
//  mis_addr_o    out  XLEN   offending target, held until next detection
//  redir_cnt_o   out  CNT_W  taken redirects + traps since reset
// BEHAVIOUR
//  Reset (rstn=0, async): state=BOOT, pc_o=RESET_VECTOR, pc_valid_o=0, misalign_o=0,
//   mis_addr_o=0, redir_cnt_o=0. flush_o=0 (all inputs qualified by state).
//  States: BOOT -> RUN unconditionally on first clk after reset release (pc_valid_o=0 in BOOT).
//   RUN: pc_valid_o=1. HALT: pc_valid_o=0, pc_o holds last value; only trap_i leaves HALT.
//  Target (mod 2^XLEN, no overflow flag): BRANCH taken / JUMP: ex_pc_i+ex_imm_i;
//   JALR: (ex_rs1_i+ex_imm_i) & ~1. BRANCH not-taken, PLUS4, codes 4..7: no redirect.
//  Redirect = ex_valid_i && target op (above) && state==RUN.
//  Priority per cycle: trap_i > redirect > accept > hold.
//   trap_i (any state except BOOT): pc_o<=trap_vec_i, state<=RUN, flush_o=1, cnt+1. No align check.
//   redirect, aligned: pc_o<=target, flush_o=1, cnt+1; unaccepted pc_o discarded.
//   redirect, misaligned: state<=HALT, flush_o=1, misalign_o<=1, mis_addr_o<=target, cnt unchanged.
//   accept only: pc_o<=pc_o+(4), wraps at 2^XLEN.   neither: pc_o held (stable under back-pressure).
//  Latency: redirect/trap visible on pc_o the next cycle with pc_valid_o=1 (1-cycle bubble-free).
//  Simultaneous accept+redirect: accept is void (flush_o=1); no +4 step.
//  ex_valid_i/trap_i in BOOT ignored. ex_valid_i in HALT ignored.
//  redir_cnt_o saturates at 2^CNT_W-1.
//  Reset mid-operation: immediate return to reset values; pending state lost.
// TESTING
//  T1 reset: rstn 0->1 -> cycle1 pc_valid_o=0, cycle2 pc_o=RESET_VECTOR, pc_valid_o=1.
//  T2 back-pressure: ready pattern 1,0,0,1 from PC 0x0 -> pc_o 0x4,0x4,0x4,0x8; no skips/repeats.
//  T3 branch: ex_pc=0x100, imm=-8, BRANCH taken, ready=1 -> flush_o=1, next pc_o=0xF8, cnt=1;
//   same with taken=0 -> no flush, pc continues +4.
//  T4 JALR: rs1=0x2003, imm=0 -> pc_o=0x2002 (C_EXT=1); with C_EXT=0 -> misalign_o pulse,
//   mis_addr_o=0x2002, HALT, pc_valid_o=0; trap_i vec=0x80 -> pc_o=0x80, RUN.
//  T5 trap vs redirect same cycle: trap_vec=0x80, JUMP target 0x400 -> pc_o=0x80, cnt+1 once.
//  T6 wrap/saturate: pc_o=0xFFFF_FFFC accepted -> 0x0; CNT_W=2, 5 redirects -> redir_cnt_o=3;
//   rstn pulse mid-stream -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch-PC generator: registered PC with valid/ready handoff to fetch, redirect
// and trap resolution, misaligned-target detection and a saturating redirect counter.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter bit              C_EXT        = 1'b0,
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rstn,
  output logic [XLEN-1:0]  pc_o,
  output logic             pc_valid_o,
  input  logic             pc_ready_i,
  input  logic             ex_valid_i,
  input  logic [2:0]       ex_pcsrc_i,
  input  logic             ex_taken_i,
  input  logic [XLEN-1:0]  ex_pc_i,
  input  logic [XLEN-1:0]  ex_imm_i,
  input  logic [XLEN-1:0]  ex_rs1_i,
  input  logic             trap_i,
  input  logic [XLEN-1:0]  trap_vec_i,
  output logic             flush_o,
  output logic             misalign_o,
  output logic [XLEN-1:0]  mis_addr_o,
  output logic [CNT_W-1:0] redir_cnt_o
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

  typedef enum logic [2:0] {
    SRC_PLUS4  = 3'd0,
    SRC_BRANCH = 3'd1,
    SRC_JUMP   = 3'd2,
    SRC_JALR   = 3'd3
  } pcsrc_e;

  state_e            state, state_nxt;
  logic [XLEN-1:0]   target;
  logic              target_op;
  logic              aligned;
  logic              take_trap;
  logic              redirect;
  logic              accept;
  logic [XLEN-1:0]   pc_nxt;
  logic              misalign_nxt;
  logic [XLEN-1:0]   mis_addr_nxt;
  logic              cnt_inc;
  logic [CNT_W-1:0]  cnt_nxt;

  // NOTE: every always_comb output is given a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    target_op = 1'b0;
    target    = ex_pc_i + ex_imm_i;
    case (pcsrc_e'(ex_pcsrc_i))
      SRC_BRANCH: target_op = ex_taken_i;
      SRC_JUMP:   target_op = 1'b1;
      SRC_JALR: begin
        target_op = 1'b1;
        target    = (ex_rs1_i + ex_imm_i) & ~XLEN'(1);
      end
      default:    target_op = 1'b0;
    endcase
  end

  assign aligned    = C_EXT ? ~target[0] : (target[1:0] == 2'b00);
  assign take_trap  = trap_i && (state != BOOT);
  assign redirect   = ex_valid_i && target_op && (state == RUN);
  assign pc_valid_o = (state == RUN);
  assign accept     = pc_valid_o && pc_ready_i;
  assign flush_o    = take_trap || redirect;

  // Priority: trap > redirect > accept > hold. A misaligned redirect still
  // flushes, but parks the generator in HALT until a trap arrives.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_o;
    misalign_nxt = 1'b0;
    mis_addr_nxt = mis_addr_o;
    cnt_inc      = 1'b0;
    if (state == BOOT) begin
      state_nxt = RUN;
    end else if (take_trap) begin
      state_nxt = RUN;
      pc_nxt    = trap_vec_i;
      cnt_inc   = 1'b1;
    end else if (redirect) begin
      if (aligned) begin
        pc_nxt  = target;
        cnt_inc = 1'b1;
      end else begin
        state_nxt    = HALT;
        misalign_nxt = 1'b1;
        mis_addr_nxt = target;
      end
    end else if (accept) begin
      pc_nxt = pc_o + XLEN'(4);
    end
  end

  assign cnt_nxt = (cnt_inc && (redir_cnt_o != {CNT_W{1'b1}})) ? redir_cnt_o + CNT_W'(1)
                                                                : redir_cnt_o;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= BOOT;
      pc_o        <= RESET_VECTOR;
      misalign_o  <= 1'b0;
      mis_addr_o  <= '0;
      redir_cnt_o <= '0;
    end else begin
      state       <= state_nxt;
      pc_o        <= pc_nxt;
      misalign_o  <= misalign_nxt;
      mis_addr_o  <= mis_addr_nxt;
      redir_cnt_o <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: two instances (4-byte alignment / 16-bit counter and 2-byte
// alignment / 2-bit counter) share stimulus and are checked against a reference model.
module tb_pc_gen;

  localparam int ST_BOOT = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_HALT = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        pc_ready;
  logic        ex_valid;
  logic [2:0]  ex_pcsrc;
  logic        ex_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic        trap;
  logic [31:0] trap_vec;

  logic [31:0] pc0, pc1, maddr0, maddr1;
  logic        valid0, valid1, flush0, flush1, mis0, mis1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  int total = 0;
  int bad   = 0;

  // Reference model state, one slot per instance.
  int          m_state[2];
  logic [31:0] m_pc[2];
  bit          m_mis[2];
  logic [31:0] m_maddr[2];
  int          m_cnt[2];
  bit          c_ext[2]   = '{1'b0, 1'b1};
  int          cnt_max[2] = '{65535, 3};

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .C_EXT(1'b0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rstn(rstn), .pc_o(pc0), .pc_valid_o(valid0), .pc_ready_i(pc_ready),
    .ex_valid_i(ex_valid), .ex_pcsrc_i(ex_pcsrc), .ex_taken_i(ex_taken), .ex_pc_i(ex_pc),
    .ex_imm_i(ex_imm), .ex_rs1_i(ex_rs1), .trap_i(trap), .trap_vec_i(trap_vec),
    .flush_o(flush0), .misalign_o(mis0), .mis_addr_o(maddr0), .redir_cnt_o(cnt0)
  );

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .C_EXT(1'b1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rstn(rstn), .pc_o(pc1), .pc_valid_o(valid1), .pc_ready_i(pc_ready),
    .ex_valid_i(ex_valid), .ex_pcsrc_i(ex_pcsrc), .ex_taken_i(ex_taken), .ex_pc_i(ex_pc),
    .ex_imm_i(ex_imm), .ex_rs1_i(ex_rs1), .trap_i(trap), .trap_vec_i(trap_vec),
    .flush_o(flush1), .misalign_o(mis1), .mis_addr_o(maddr1), .redir_cnt_o(cnt1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired before the test ended");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_op();
    if (ex_pcsrc == 3'd1) return ex_taken;
    return (ex_pcsrc == 3'd2) || (ex_pcsrc == 3'd3);
  endfunction

  function automatic logic [31:0] m_target();
    if (ex_pcsrc == 3'd3) return (ex_rs1 + ex_imm) & 32'hFFFF_FFFE;
    return ex_pc + ex_imm;
  endfunction

  function automatic bit m_aligned(input int i, input logic [31:0] t);
    return c_ext[i] ? (t % 2 == 0) : (t % 4 == 0);
  endfunction

  function automatic bit m_flush(input int i);
    return (trap && m_state[i] != ST_BOOT) || (ex_valid && m_op() && m_state[i] == ST_RUN);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = ST_BOOT;
      m_pc[i]    = 32'h0;
      m_mis[i]   = 1'b0;
      m_maddr[i] = 32'h0;
      m_cnt[i]   = 0;
    end
  endtask

  task automatic model_step();
    logic [31:0] t;
    if (!rstn) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      m_mis[i] = 1'b0;
      if (m_state[i] == ST_BOOT) begin
        m_state[i] = ST_RUN;
      end else if (trap) begin
        m_pc[i]    = trap_vec;
        m_state[i] = ST_RUN;
        if (m_cnt[i] < cnt_max[i]) m_cnt[i]++;
      end else if (m_state[i] == ST_RUN && ex_valid && m_op()) begin
        t = m_target();
        if (m_aligned(i, t)) begin
          m_pc[i] = t;
          if (m_cnt[i] < cnt_max[i]) m_cnt[i]++;
        end else begin
          m_state[i] = ST_HALT;
          m_mis[i]   = 1'b1;
          m_maddr[i] = t;
        end
      end else if (m_state[i] == ST_RUN && pc_ready) begin
        m_pc[i] = m_pc[i] + 32'd4;
      end
    end
  endtask

  task automatic compare_all();
    check("pc0",    pc0,    m_pc[0]);
    check("valid0", valid0, 32'(m_state[0] == ST_RUN));
    check("flush0", flush0, 32'(m_flush(0)));
    check("mis0",   mis0,   32'(m_mis[0]));
    check("maddr0", maddr0, m_maddr[0]);
    check("cnt0",   cnt0,   m_cnt[0]);
    check("pc1",    pc1,    m_pc[1]);
    check("valid1", valid1, 32'(m_state[1] == ST_RUN));
    check("flush1", flush1, 32'(m_flush(1)));
    check("mis1",   mis1,   32'(m_mis[1]));
    check("maddr1", maddr1, m_maddr[1]);
    check("cnt1",   cnt1,   m_cnt[1]);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    #1 compare_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    pc_ready = 1'b0; ex_valid = 1'b0; ex_pcsrc = 3'd0; ex_taken = 1'b0;
    ex_pc = '0; ex_imm = '0; ex_rs1 = '0; trap = 1'b0; trap_vec = '0;
  endtask

  task automatic reset_pulse();
    #2 rstn = 1'b0;
    #1 model_reset();
    compare_all();
    check("rst_async_pc",    pc0,    32'h0);
    check("rst_async_valid", valid1, 32'h0);
    check("rst_async_cnt",   cnt0,   32'h0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    #1 compare_all();
    check("t1_rst_pc",    pc0,    32'h0);
    check("t1_rst_valid", valid0, 32'h0);
    check("t1_rst_mis",   mis0,   32'h0);
    check("t1_rst_maddr", maddr0, 32'h0);
    check("t1_rst_cnt",   cnt0,   32'h0);
    check("t1_rst_flush", flush0, 32'h0);

    // T1: one BOOT cycle, then RUN at the reset vector.
    @(negedge clk);
    rstn = 1'b1;
    #1 check("t1_cycle1_valid", valid0, 32'h0);
    tick();
    check("t1_cycle2_valid", valid0, 32'h1);
    check("t1_cycle2_pc",    pc0,    32'h0);

    // T2: back-pressure pattern 1,0,0,1.
    pc_ready = 1'b1; tick(); check("t2_pc_a", pc0, 32'h4);
    pc_ready = 1'b0; tick(); check("t2_pc_b", pc0, 32'h4);
    pc_ready = 1'b0; tick(); check("t2_pc_c", pc0, 32'h4);
    pc_ready = 1'b1; tick(); check("t2_pc_d", pc0, 32'h8);

    // T3: taken branch with accept in the same cycle, then not-taken.
    ex_valid = 1'b1; ex_pcsrc = 3'd1; ex_taken = 1'b1; ex_pc = 32'h100; ex_imm = -32'sd8;
    #1 check("t3_flush", flush0, 32'h1);
    tick();
    check("t3_pc",  pc0,  32'hF8);
    check("t3_cnt", cnt0, 32'h1);
    ex_taken = 1'b0;
    #1 check("t3_nt_flush", flush0, 32'h0);
    tick();
    check("t3_nt_pc", pc0, 32'hFC);

    // T4: JALR to 0x2002 - legal with 2-byte alignment, misaligned otherwise.
    ex_pcsrc = 3'd3; ex_rs1 = 32'h2003; ex_imm = 32'h0;
    tick();
    check("t4_pc_cext",   pc1,    32'h2002);
    check("t4_mis_pulse", mis0,   32'h1);
    check("t4_mis_addr",  maddr0, 32'h2002);
    check("t4_halt_valid", valid0, 32'h0);
    check("t4_halt_cnt",  cnt0,   32'h1);
    ex_pcsrc = 3'd2; ex_pc = 32'h500;
    #1 check("t4_halt_ignores_ex", flush0, 32'h0);
    tick();
    check("t4_mis_cleared", mis0,  32'h0);
    check("t4_halt_pc",     pc0,   32'hFC);
    ex_valid = 1'b0; trap = 1'b1; trap_vec = 32'h80;
    #1 check("t4_trap_flush", flush0, 32'h1);
    tick();
    check("t4_trap_pc",    pc0,    32'h80);
    check("t4_trap_valid", valid0, 32'h1);

    // T5: trap outranks a simultaneous jump.
    ex_valid = 1'b1; ex_pcsrc = 3'd2; ex_pc = 32'h300; ex_imm = 32'h100;
    tick();
    check("t5_pc",  pc0,  32'h80);
    check("t5_cnt", cnt0, 32'h3);

    // T6: wrap at the top of the address space, counter saturation.
    ex_valid = 1'b0; trap_vec = 32'hFFFF_FFFC;
    tick();
    check("t6_top_pc", pc0, 32'hFFFF_FFFC);
    trap = 1'b0; pc_ready = 1'b1;
    tick();
    check("t6_wrap_pc",  pc0,  32'h0);
    check("t6_cnt_w16",  cnt0, 32'h4);
    check("t6_cnt_sat",  cnt1, 32'h3);
    reset_pulse();
    idle();

    // Randomized phase with occasional asynchronous reset.
    for (int n = 0; n < 3000; n++) begin
      pc_ready = ($urandom_range(0, 3) != 0);
      ex_valid = ($urandom_range(0, 1) == 1);
      ex_pcsrc = 3'($urandom_range(0, 7));
      ex_taken = ($urandom_range(0, 1) == 1);
      ex_pc    = $urandom & 32'hFFFF_FFFC;
      ex_imm   = 32'($signed($urandom_range(0, 255)) - 128);
      ex_rs1   = $urandom;
      trap     = ($urandom_range(0, 7) == 0);
      trap_vec = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      if ($urandom_range(0, 299) == 0) reset_pulse();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
